// File: rtl/led_blinker_pkg.sv
// rtl/led_blinker_pkg.sv - shared mode type and helpers for the LED blinker bank
package led_blinker_pkg;

    // Channel operating mode; values match the wr_mode codes
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    localparam logic [1:0] MODE_CODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_CODE_ON    = 2'd1;
    localparam logic [1:0] MODE_CODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CODE_PULSE = 2'd3;

    // Every mode except OFF lights the LED on entry
    function automatic logic mode_lights(input mode_e m);
        return (m != MODE_OFF);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle base tick
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap; clr realigns the phase to zero
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_blinker_bank.sv
// rtl/led_blinker_bank.sv - bank of OFF/ON/BLINK/PULSE LED channels; LED_BLINKER_SYNC_EN adds phase-align input
module led_blinker_bank
    import led_blinker_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int TICK_DIV = 100000,
    parameter int PERIOD_W = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
`ifdef LED_BLINKER_SYNC_EN
    input  logic                                     sync,
`endif
    input  logic                                     wr_en,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
    input  logic [1:0]                               wr_mode,
    input  logic [PERIOD_W-1:0]                      wr_period,
    output logic [N_CH-1:0]                          led,
    output logic [N_CH-1:0]                          busy,
    output logic [N_CH-1:0]                          done
);

    logic                w_tick;
    mode_e               w_wr_mode;
    logic [PERIOD_W-1:0] w_wr_period;

    assign w_wr_mode   = mode_e'(wr_mode);
    assign w_wr_period = (wr_period == '0) ? PERIOD_W'(1) : wr_period;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
`ifdef LED_BLINKER_SYNC_EN
        .clr   (sync),
`else
        .clr   (1'b0),
`endif
        .tick  (w_tick)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mode_e               r_mode;
        logic [PERIOD_W-1:0] r_period;
        logic [PERIOD_W-1:0] r_cnt;
        logic                r_led;
        logic                r_busy;
        logic                r_done;
        logic                w_hit;
        logic                w_last;

        // Out-of-range channel numbers never match any generated index
        assign w_hit  = wr_en && (int'(wr_ch) == g);
        assign w_last = (r_cnt == r_period - PERIOD_W'(1));

        // Channel state: write beats sync beats tick
        always_ff @(posedge clk) begin
            if (reset) begin
                r_mode   <= MODE_OFF;
                r_period <= PERIOD_W'(1);
                r_cnt    <= '0;
                r_led    <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (w_hit) begin
                    r_mode   <= w_wr_mode;
                    r_period <= w_wr_period;
                    r_cnt    <= '0;
                    r_led    <= mode_lights(w_wr_mode);
                    r_busy   <= (w_wr_mode == MODE_PULSE);
                end
`ifdef LED_BLINKER_SYNC_EN
                else if (sync) begin
                    r_cnt <= '0;
                    if (r_mode == MODE_BLINK) begin
                        r_led <= 1'b1;
                    end
                end
`endif
                else if (w_tick) begin
                    case (r_mode)
                        MODE_BLINK: begin
                            if (w_last) begin
                                r_led <= ~r_led;
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + PERIOD_W'(1);
                            end
                        end
                        MODE_PULSE: begin
                            if (w_last) begin
                                r_mode <= MODE_OFF;
                                r_led  <= 1'b0;
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
                                r_cnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt + PERIOD_W'(1);
                            end
                        end
                        default: r_cnt <= '0;
                    endcase
                end
            end
        end

        assign led[g]  = r_led;
        assign busy[g] = r_busy;
        assign done[g] = r_done;
    end

endmodule
